flu_len_meter: RTL and testbench
================================

Name: flu_len_meter

Overview:
- Streaming FrameLinkUnaligned (FLU) stage placed directly downstream of the FLU async FIFO TX port, in the consumer clock domain.
- Forwards the FLU stream through one register stage.
- Measures every frame's length in bytes and emits it on a separate valid/ready length channel, one entry per frame.

Parameters:
DATA_WIDTH, 512, FLU data width in bits; multiple of 64
SOP_POS_WIDTH, 3, SOP position width; block = DATA_WIDTH/(8*2**SOP_POS_WIDTH) bytes
LEN_WIDTH, 16, width of reported frame length in bytes
MTU, 16383, maximum legal frame length in bytes (optional feature only)

Ports:
CLK  in  1  clock
RESET  in  1  asynchronous reset, active-low
RX_DATA  in  DATA_WIDTH  FLU data
RX_SOP_POS  in  SOP_POS_WIDTH  SOP block index
RX_EOP_POS  in  log2(DATA_WIDTH/8)  EOP byte index
RX_SOP  in  1  start of packet in word
RX_EOP  in  1  end of packet in word
RX_SRC_RDY  in  1  upstream valid
RX_DST_RDY  out  1  ready to upstream
TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP  out  as RX  registered FLU word
TX_SRC_RDY  out  1  word valid
TX_DST_RDY  in  1  downstream ready
LEN  out  LEN_WIDTH  frame length in bytes, saturating
LEN_SRC_RDY  out  1  length valid
LEN_DST_RDY  in  1  length consumer ready
PROTO_ERR  out  1  sticky: SOP seen while a frame is open

Behaviour:
- Reset (RESET=0, async): TX_SRC_RDY=0, LEN_SRC_RDY=0, LEN=0, PROTO_ERR=0, byte counter=0, in_frame=0; TX_* data fields reset to 0.
- Transfer rules: RX transfer = RX_SRC_RDY & RX_DST_RDY; TX and LEN transfers are defined the same way.
- RX_DST_RDY = (!TX_SRC_RDY | TX_DST_RDY) & (!LEN_SRC_RDY | LEN_DST_RDY). This is combinational; no bubble at full throughput.
- Latency: an RX word appears on TX one cycle after its transfer. An RX word carrying EOP raises LEN_SRC_RDY in that same following cycle. TX and LEN are held stable until their own handshakes complete.
- Byte arithmetic: W = DATA_WIDTH/8; B = W/2**SOP_POS_WIDTH; s = RX_SOP_POS*B; e = RX_EOP_POS+1. Computation width is LEN_WIDTH+1; LEN saturates at 2**LEN_WIDTH-1.
- Per RX transfer, when idle (in_frame=0):
  - SOP only: cnt=W-s; in_frame=1.
  - SOP&EOP with e>s: single-word frame; LEN=e-s.
  - Neither: word ignored for counting but still forwarded.
- Per RX transfer, when in_frame=1:
  - Neither: cnt+=W.
  - EOP only: LEN=cnt+e; in_frame=0.
  - SOP&EOP with e<=s: LEN=cnt+e (old frame closes); cnt=W-s; in_frame stays 1.
  - SOP without EOP: PROTO_ERR<=1; old frame is dropped from measurement (no LEN emitted); cnt=W-s.
  - SOP&EOP with e>s: PROTO_ERR<=1; LEN=e-s (new single-word frame reported).
- Consequence of the stall rule: LEN never overflows its slot. A second EOP cannot be accepted while LEN is pending and unaccepted, because RX_DST_RDY is low.
- Reset mid-frame: the open frame is forgotten and no LEN is emitted for it. PROTO_ERR clears only on reset.

Optional Feature:
FLU_LEN_METER_MTU_CHECK_EN
- Defined: adds output LEN_MTU_ERR (1 bit), valid with LEN. It is 1 when the final length > MTU or the counter saturated; it is 0 otherwise.
- Not defined: the port does not exist and MTU is unused.

Decomposition:
- Package flu_len_meter_pkg holds:
  - function for log2 widths;
  - typedef flu_word_t (data, sop_pos, eop_pos, sop, eop);
  - typedef len_t (logic [LEN_WIDTH-1:0]);
  - saturating-add function.
- One sub-module: flu_len_meter_calc. It is combinational: current counter, in_frame, and RX control fields in; next counter, next in_frame, emit-flag, length, and protocol-error pulse out. The top level holds the TX register and the LEN slot.

Test Plan:
- Single-word frame, SOP_POS=1, EOP_POS=39 (B=8) -> TX word after 1 cycle; LEN=32, LEN_SRC_RDY=1 in the same cycle.
- Three-word frame: SOP_POS=0, middle word, EOP_POS=9 -> LEN=138 (64+64+10); RX_DST_RDY stays 1 throughout.
- Word with EOP_POS=15 and SOP_POS=4 closing a frame opened at SOP_POS=0 previous word -> LEN=80. Next word EOP_POS=7 -> second LEN=32+8=40.
- LEN_DST_RDY=0 with two back-to-back single-word frames -> RX_DST_RDY drops after the first; second accepted only after LEN handshake; no length lost.
- SOP, SOP (no EOP between) -> PROTO_ERR=1 from the cycle after the second word; only the second frame's LEN reported.
- 1100-word frame, LEN_WIDTH=16 -> LEN=65535 (saturated). With the macro defined, LEN_MTU_ERR=1.

Source files
------------

// File: rtl/flu_len_meter_pkg.sv
// Shared types and helpers for the FLU frame-length meter.
// The optional MTU check is enabled by defining FLU_LEN_METER_MTU_CHECK_EN.
package flu_len_meter_pkg;

    function automatic int unsigned clog2_w(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned p = 1; p < v; p = p << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    localparam int unsigned FLU_DATA_WIDTH    = 512;
    localparam int unsigned FLU_SOP_POS_WIDTH = 3;
    localparam int unsigned FLU_LEN_WIDTH     = 16;
    localparam int unsigned FLU_EOP_POS_WIDTH = clog2_w(FLU_DATA_WIDTH / 8);

    typedef struct packed {
        logic [FLU_DATA_WIDTH-1:0]    data;
        logic [FLU_SOP_POS_WIDTH-1:0] sop_pos;
        logic [FLU_EOP_POS_WIDTH-1:0] eop_pos;
        logic                         sop;
        logic                         eop;
    } flu_word_t;

    typedef logic [FLU_LEN_WIDTH-1:0] len_t;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] lim);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[31:0];
    endfunction

endpackage

// File: rtl/flu_len_meter_calc.sv
// Combinational next-state and length calculation for one accepted FLU word.
// Exposes len_ovf only when FLU_LEN_METER_MTU_CHECK_EN is defined.
module flu_len_meter_calc
    import flu_len_meter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned SOP_POS_WIDTH = 3,
    parameter int unsigned LEN_WIDTH     = 16,
    localparam int unsigned EOP_POS_WIDTH = clog2_w(DATA_WIDTH / 8),
    localparam int unsigned CW            = LEN_WIDTH + 1
) (
    input  logic [CW-1:0]            cnt,
    input  logic                     in_frame,
    input  logic [SOP_POS_WIDTH-1:0] sop_pos,
    input  logic [EOP_POS_WIDTH-1:0] eop_pos,
    input  logic                     sop,
    input  logic                     eop,
    output logic [CW-1:0]            cnt_nxt,
    output logic                     in_frame_nxt,
    output logic                     emit,
    output logic [LEN_WIDTH-1:0]     len,
`ifdef FLU_LEN_METER_MTU_CHECK_EN
    output logic                     len_ovf,
`endif
    output logic                     proto_err
);

    localparam int unsigned W    = DATA_WIDTH / 8;
    localparam int unsigned B    = W / (2 ** SOP_POS_WIDTH);
    localparam int unsigned LMAX = (1 << LEN_WIDTH) - 1;

    logic [31:0] s, e, w_s, sum;

    always_comb begin
        s            = 32'(sop_pos) * B;
        e            = 32'(eop_pos) + 32'd1;
        w_s          = W - s;
        sum          = '0;
        cnt_nxt      = cnt;
        in_frame_nxt = in_frame;
        emit         = 1'b0;
        proto_err    = 1'b0;
        if (!in_frame) begin
            if (sop && eop && e > s) begin
                emit = 1'b1;
                sum  = e - s;
            end else if (sop) begin
                cnt_nxt      = CW'(w_s);
                in_frame_nxt = 1'b1;
            end
        end else begin
            if (sop && eop && e > s) begin
                proto_err    = 1'b1;
                emit         = 1'b1;
                sum          = e - s;
                in_frame_nxt = 1'b0;
            end else if (sop && eop) begin
                emit    = 1'b1;
                sum     = 32'(cnt) + e;
                cnt_nxt = CW'(w_s);
            end else if (sop) begin
                proto_err = 1'b1;
                cnt_nxt   = CW'(w_s);
            end else if (eop) begin
                emit         = 1'b1;
                sum          = 32'(cnt) + e;
                in_frame_nxt = 1'b0;
            end else begin
                // Counter parks one above LMAX so a saturated frame stays detectable at EOP.
                cnt_nxt = CW'(sat_add(32'(cnt), W, LMAX + 1));
            end
        end
        len = (sum > LMAX) ? LEN_WIDTH'(LMAX) : LEN_WIDTH'(sum);
`ifdef FLU_LEN_METER_MTU_CHECK_EN
        len_ovf = (sum > LMAX);
`endif
    end

endmodule

// File: rtl/flu_len_meter.sv
// FLU register stage that measures each frame's byte length onto a separate channel.
// Define FLU_LEN_METER_MTU_CHECK_EN to add the MTU parameter and LEN_MTU_ERR output.
module flu_len_meter
    import flu_len_meter_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = 512,
    parameter int unsigned SOP_POS_WIDTH = 3,
    parameter int unsigned LEN_WIDTH     = 16,
`ifdef FLU_LEN_METER_MTU_CHECK_EN
    parameter int unsigned MTU           = 16383,
`endif
    localparam int unsigned EOP_POS_WIDTH = clog2_w(DATA_WIDTH / 8)
) (
    input  logic                     CLK,
    input  logic                     RESET,
    input  logic [DATA_WIDTH-1:0]    RX_DATA,
    input  logic [SOP_POS_WIDTH-1:0] RX_SOP_POS,
    input  logic [EOP_POS_WIDTH-1:0] RX_EOP_POS,
    input  logic                     RX_SOP,
    input  logic                     RX_EOP,
    input  logic                     RX_SRC_RDY,
    output logic                     RX_DST_RDY,
    output logic [DATA_WIDTH-1:0]    TX_DATA,
    output logic [SOP_POS_WIDTH-1:0] TX_SOP_POS,
    output logic [EOP_POS_WIDTH-1:0] TX_EOP_POS,
    output logic                     TX_SOP,
    output logic                     TX_EOP,
    output logic                     TX_SRC_RDY,
    input  logic                     TX_DST_RDY,
    output logic [LEN_WIDTH-1:0]     LEN,
    output logic                     LEN_SRC_RDY,
    input  logic                     LEN_DST_RDY,
`ifdef FLU_LEN_METER_MTU_CHECK_EN
    output logic                     LEN_MTU_ERR,
`endif
    output logic                     PROTO_ERR
);

    logic [LEN_WIDTH:0]   cnt, cnt_nxt;
    logic                 in_frame, in_frame_nxt;
    logic                 emit, proto_pulse;
    logic [LEN_WIDTH-1:0] len_nxt;
    logic                 rx_xfer;
`ifdef FLU_LEN_METER_MTU_CHECK_EN
    logic                 len_ovf;
`endif

    assign RX_DST_RDY = (!TX_SRC_RDY || TX_DST_RDY) && (!LEN_SRC_RDY || LEN_DST_RDY);
    assign rx_xfer    = RX_SRC_RDY && RX_DST_RDY;

    flu_len_meter_calc #(
        .DATA_WIDTH   (DATA_WIDTH),
        .SOP_POS_WIDTH(SOP_POS_WIDTH),
        .LEN_WIDTH    (LEN_WIDTH)
    ) u_calc (
        .cnt         (cnt),
        .in_frame    (in_frame),
        .sop_pos     (RX_SOP_POS),
        .eop_pos     (RX_EOP_POS),
        .sop         (RX_SOP),
        .eop         (RX_EOP),
        .cnt_nxt     (cnt_nxt),
        .in_frame_nxt(in_frame_nxt),
        .emit        (emit),
        .len         (len_nxt),
`ifdef FLU_LEN_METER_MTU_CHECK_EN
        .len_ovf     (len_ovf),
`endif
        .proto_err   (proto_pulse)
    );

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            TX_DATA    <= '0;
            TX_SOP_POS <= '0;
            TX_EOP_POS <= '0;
            TX_SOP     <= 1'b0;
            TX_EOP     <= 1'b0;
            TX_SRC_RDY <= 1'b0;
            cnt        <= '0;
            in_frame   <= 1'b0;
            PROTO_ERR  <= 1'b0;
        end else if (rx_xfer) begin
            TX_DATA    <= RX_DATA;
            TX_SOP_POS <= RX_SOP_POS;
            TX_EOP_POS <= RX_EOP_POS;
            TX_SOP     <= RX_SOP;
            TX_EOP     <= RX_EOP;
            TX_SRC_RDY <= 1'b1;
            cnt        <= cnt_nxt;
            in_frame   <= in_frame_nxt;
            if (proto_pulse) PROTO_ERR <= 1'b1;
        end else if (TX_DST_RDY) begin
            TX_SRC_RDY <= 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            LEN         <= '0;
            LEN_SRC_RDY <= 1'b0;
`ifdef FLU_LEN_METER_MTU_CHECK_EN
            LEN_MTU_ERR <= 1'b0;
`endif
        end else if (rx_xfer && emit) begin
            LEN         <= len_nxt;
            LEN_SRC_RDY <= 1'b1;
`ifdef FLU_LEN_METER_MTU_CHECK_EN
            LEN_MTU_ERR <= len_ovf || (32'(len_nxt) > MTU);
`endif
        end else if (LEN_DST_RDY) begin
            LEN_SRC_RDY <= 1'b0;
        end
    end

endmodule

// File: tb/tb_flu_len_meter.sv
// Directed scoreboard bench for flu_len_meter (default parameters).
// Also checks LEN_MTU_ERR when built with FLU_LEN_METER_MTU_CHECK_EN.
module tb_flu_len_meter;
    import flu_len_meter_pkg::*;

    logic                         CLK = 1'b0;
    logic                         RESET;
    logic [FLU_DATA_WIDTH-1:0]    RX_DATA;
    logic [FLU_SOP_POS_WIDTH-1:0] RX_SOP_POS;
    logic [FLU_EOP_POS_WIDTH-1:0] RX_EOP_POS;
    logic                         RX_SOP, RX_EOP, RX_SRC_RDY, RX_DST_RDY;
    logic [FLU_DATA_WIDTH-1:0]    TX_DATA;
    logic [FLU_SOP_POS_WIDTH-1:0] TX_SOP_POS;
    logic [FLU_EOP_POS_WIDTH-1:0] TX_EOP_POS;
    logic                         TX_SOP, TX_EOP, TX_SRC_RDY, TX_DST_RDY;
    len_t                         LEN;
    logic                         LEN_SRC_RDY, LEN_DST_RDY, PROTO_ERR;
`ifdef FLU_LEN_METER_MTU_CHECK_EN
    logic                         LEN_MTU_ERR;
`endif

    int checks   = 0;
    int failures = 0;

    flu_word_t tx_q[$];
    int        len_q[$];
    logic      mtu_q[$];

    always #5 CLK = ~CLK;

    flu_len_meter dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .RX_DATA    (RX_DATA),
        .RX_SOP_POS (RX_SOP_POS),
        .RX_EOP_POS (RX_EOP_POS),
        .RX_SOP     (RX_SOP),
        .RX_EOP     (RX_EOP),
        .RX_SRC_RDY (RX_SRC_RDY),
        .RX_DST_RDY (RX_DST_RDY),
        .TX_DATA    (TX_DATA),
        .TX_SOP_POS (TX_SOP_POS),
        .TX_EOP_POS (TX_EOP_POS),
        .TX_SOP     (TX_SOP),
        .TX_EOP     (TX_EOP),
        .TX_SRC_RDY (TX_SRC_RDY),
        .TX_DST_RDY (TX_DST_RDY),
        .LEN        (LEN),
        .LEN_SRC_RDY(LEN_SRC_RDY),
        .LEN_DST_RDY(LEN_DST_RDY),
`ifdef FLU_LEN_METER_MTU_CHECK_EN
        .LEN_MTU_ERR(LEN_MTU_ERR),
`endif
        .PROTO_ERR  (PROTO_ERR)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one word and waits (bounded) for its transfer; stalls = cycles RX_DST_RDY was low.
    task automatic send(input logic sop, input logic eop, input int sp, input int ep,
                        output int stalls);
        flu_word_t w;
        for (int i = 0; i < FLU_DATA_WIDTH / 32; i++) w.data[i*32 +: 32] = $urandom;
        w.sop_pos  = FLU_SOP_POS_WIDTH'(sp);
        w.eop_pos  = FLU_EOP_POS_WIDTH'(ep);
        w.sop      = sop;
        w.eop      = eop;
        RX_DATA    = w.data;
        RX_SOP_POS = w.sop_pos;
        RX_EOP_POS = w.eop_pos;
        RX_SOP     = sop;
        RX_EOP     = eop;
        RX_SRC_RDY = 1'b1;
        stalls     = 0;
        @(negedge CLK);
        while (!RX_DST_RDY && stalls < 200) begin
            stalls++;
            @(negedge CLK);
        end
        if (!RX_DST_RDY) check("rx_accept_timeout", RX_DST_RDY, 1);
        else tx_q.push_back(w);
        @(posedge CLK);
        #1;
        RX_SRC_RDY = 1'b0;
    endtask

    task automatic expect_len(input int l, input logic mtu);
        len_q.push_back(l);
        mtu_q.push_back(mtu);
    endtask

    // Output monitor: handshakes sampled mid-cycle complete on the next rising edge.
    always @(negedge CLK) begin
        if (RESET === 1'b1) begin
            if (TX_SRC_RDY && TX_DST_RDY) begin
                flu_word_t exp_w, got_w;
                got_w = '{TX_DATA, TX_SOP_POS, TX_EOP_POS, TX_SOP, TX_EOP};
                exp_w = '0;
                if (tx_q.size() == 0) check("tx_unexpected", 1, 0);
                else begin
                    exp_w = tx_q.pop_front();
                    checks++;
                    assert (got_w === exp_w) else begin
                        failures++;
                        $error("FAIL tx_word observed sop=%0b eop=%0b sp=%0d ep=%0d d=%0h expected sop=%0b eop=%0b sp=%0d ep=%0d d=%0h",
                               got_w.sop, got_w.eop, got_w.sop_pos, got_w.eop_pos, got_w.data[63:0],
                               exp_w.sop, exp_w.eop, exp_w.sop_pos, exp_w.eop_pos, exp_w.data[63:0]);
                    end
                end
            end
            if (LEN_SRC_RDY && LEN_DST_RDY) begin
                if (len_q.size() == 0) check("len_unexpected", 64'(LEN), 0);
                else begin
                    int   l;
                    logic m;
                    l = len_q.pop_front();
                    m = mtu_q.pop_front();
                    check("len_value", 64'(LEN), 64'(l));
`ifdef FLU_LEN_METER_MTU_CHECK_EN
                    check("len_mtu_err", 64'(LEN_MTU_ERR), 64'(m));
`endif
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        RESET      = 1'b0;
        RX_DATA    = '0;
        RX_SOP_POS = '0;
        RX_EOP_POS = '0;
        RX_SOP     = 1'b0;
        RX_EOP     = 1'b0;
        RX_SRC_RDY = 1'b0;
        TX_DST_RDY = 1'b1;
        LEN_DST_RDY = 1'b1;
        #2;
        check("rst_tx_src_rdy", TX_SRC_RDY, 0);
        check("rst_len_src_rdy", LEN_SRC_RDY, 0);
        check("rst_len", 64'(LEN), 0);
        check("rst_proto_err", PROTO_ERR, 0);
        check("rst_tx_data_lo", TX_DATA[63:0], 0);
        repeat (3) @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;

        // Single-word frame: s=8, e=40 -> 32, visible with the TX word
        expect_len(32, 1'b0);
        send(1, 1, 1, 39, st);
        check("single_tx_valid", TX_SRC_RDY, 1);
        check("single_len_valid", LEN_SRC_RDY, 1);
        check("single_len_now", 64'(LEN), 32);

        // Three-word frame: 64 + 64 + 10 = 138, no stalls
        expect_len(138, 1'b0);
        send(1, 0, 0, 0, st);
        check("three_stall0", st, 0);
        send(0, 0, 0, 0, st);
        check("three_stall1", st, 0);
        send(0, 1, 0, 9, st);
        check("three_stall2", st, 0);

        // Closing EOP (e=16) with new SOP (s=32): 64+16=80, then 32+8=40
        expect_len(80, 1'b0);
        expect_len(40, 1'b0);
        send(1, 0, 0, 0, st);
        send(1, 1, 4, 15, st);
        send(0, 1, 0, 7, st);

        // Back-pressure on LEN: second single-word frame waits for the handshake
        @(posedge CLK);
        #1;
        LEN_DST_RDY = 1'b0;
        expect_len(8, 1'b0);
        expect_len(16, 1'b0);
        send(1, 1, 0, 7, st);
        RX_SOP = 1'b1;
        RX_EOP = 1'b1;
        RX_SOP_POS = 3'd2;
        RX_EOP_POS = 6'd31;
        RX_SRC_RDY = 1'b1;
        repeat (3) @(negedge CLK);
        check("bp_rx_dst_rdy", RX_DST_RDY, 0);
        check("bp_len_held_valid", LEN_SRC_RDY, 1);
        check("bp_len_held_value", 64'(LEN), 8);
        @(posedge CLK);
        #1;
        LEN_DST_RDY = 1'b1;
        send(1, 1, 2, 31, st);
        check("bp_second_stall", st, 0);

        // SOP, SOP: only the second frame is measured, 56+64+64=184
        expect_len(184, 1'b0);
        send(1, 0, 0, 0, st);
        check("proto_before", PROTO_ERR, 0);
        send(1, 0, 1, 0, st);
        check("proto_after", PROTO_ERR, 1);
        send(0, 0, 0, 0, st);
        send(0, 1, 0, 63, st);
        check("proto_sticky", PROTO_ERR, 1);

        // 1100-word frame: 70400 bytes saturates to 65535
        expect_len(65535, 1'b1);
        send(1, 0, 0, 0, st);
        for (int i = 0; i < 1098; i++) send(0, 0, 0, 0, st);
        send(0, 1, 0, 63, st);

        // Reset mid-frame: the open frame is forgotten, lone EOP afterwards is not measured
        send(1, 0, 0, 0, st);
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("midrst_tx_src_rdy", TX_SRC_RDY, 0);
        check("midrst_len_src_rdy", LEN_SRC_RDY, 0);
        check("midrst_proto_err", PROTO_ERR, 0);
        @(negedge CLK);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        expect_len(64, 1'b0);
        send(0, 1, 0, 7, st);
        send(1, 1, 0, 63, st);

        for (int i = 0; i < 50 && (tx_q.size() != 0 || len_q.size() != 0); i++) @(negedge CLK);
        repeat (2) @(negedge CLK);
        check("drain_tx_q", tx_q.size(), 0);
        check("drain_len_q", len_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
